// File: rtl/scan_rotate_ctrl.sv
// Four-digit multiplexed display controller. It scans the digits, holds a nibble
// message buffer and rotates a window across it. Define SCAN_ROTATE_BOUNCE_EN for ping-pong motion.
module scan_rotate_ctrl #(
  parameter int SCAN_W  = 16,
  parameter int ROT_W   = 22,
  parameter int MSG_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       step,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] anode,
  output logic [3:0] digit,
  output logic [3:0] pos,
  output logic       busy,
  output logic       rot_tick,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] POS_LAST = 4'(MSG_LEN - 1);
  localparam logic [4:0] LEN5     = 5'(MSG_LEN);
`ifdef SCAN_ROTATE_BOUNCE_EN
  localparam logic [3:0] POS_TURN = 4'(MSG_LEN - 4);
`endif

  state_t            state_q, state_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              upd_q, upd_d;
  logic [3:0]        pos_q, pos_d;
  logic [3:0]        anode_q, anode_d;
  logic [3:0]        digit_q, digit_d;
  logic              busy_q, busy_d;
  logic              rot_tick_q, rot_tick_d;
  // The array is sized for the full 4-bit address space; only the first MSG_LEN entries are ever written.
  logic [3:0]        msg_q [16];
  logic [3:0]        msg_d [16];
`ifdef SCAN_ROTATE_BOUNCE_EN
  logic              dir_q, dir_d;
  logic              dir_next;
`endif

  logic              scan_tick;
  logic              advance;
  logic [3:0]        pos_next;
  logic [4:0]        idx_sum;
  logic [3:0]        idx;

  assign scan_tick = &scan_cnt_q;

  // Leftmost digit (sel 3) shows msg[pos]; the digits to its right show the entries that follow.
  always_comb begin
    idx_sum = {1'b0, pos_q} + 5'd3 - {3'b000, sel_q};
    idx     = (idx_sum >= LEN5) ? 4'(idx_sum - LEN5) : idx_sum[3:0];
  end

`ifdef SCAN_ROTATE_BOUNCE_EN
  always_comb begin
    dir_next = dir_q;
    if (dir_q) begin
      pos_next = pos_q - 4'd1;
      if (pos_next == 4'd0) dir_next = 1'b0;
    end else begin
      pos_next = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;
      if (pos_next == POS_TURN) dir_next = 1'b1;
    end
  end
`else
  always_comb begin
    pos_next = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;
  end
`endif

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    sel_d      = scan_tick ? sel_q + 2'd1 : sel_q;
    upd_d      = scan_tick;
    anode_d    = anode_q;
    digit_d    = digit_q;
    if (upd_q) begin
      anode_d = ~(4'b0001 << sel_q);
      digit_d = msg_q[idx];
    end

    for (int i = 0; i < 16; i++) msg_d[i] = msg_q[i];
    if (wr_en && ({1'b0, wr_addr} < LEN5)) msg_d[wr_addr] = wr_data;

    state_d    = state_q;
    rot_cnt_d  = rot_cnt_q;
    pos_d      = pos_q;
    rot_tick_d = 1'b0;
    advance    = 1'b0;
`ifdef SCAN_ROTATE_BOUNCE_EN
    dir_d      = dir_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        rot_cnt_d = '0;
        advance   = step;
        if (!pause && start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Pause freezes the counter on the cycle it is seen, so resume picks up exactly here.
        if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          rot_cnt_d = rot_cnt_q + ROT_W'(1);
          if (&rot_cnt_q) begin
            advance    = 1'b1;
            rot_tick_d = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        advance = step;
        if (!pause && start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      pos_d = pos_next;
`ifdef SCAN_ROTATE_BOUNCE_EN
      dir_d = dir_next;
`endif
    end

    if (stop) begin
      state_d    = ST_IDLE;
      pos_d      = 4'd0;
      rot_cnt_d  = '0;
      rot_tick_d = 1'b0;
`ifdef SCAN_ROTATE_BOUNCE_EN
      dir_d      = 1'b0;
`endif
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      scan_cnt_q <= '0;
      rot_cnt_q  <= '0;
      sel_q      <= 2'd0;
      upd_q      <= 1'b0;
      pos_q      <= 4'd0;
      anode_q    <= 4'b1111;
      digit_q    <= 4'h0;
      busy_q     <= 1'b0;
      rot_tick_q <= 1'b0;
      for (int i = 0; i < 16; i++) msg_q[i] <= 4'h0;
`ifdef SCAN_ROTATE_BOUNCE_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      rot_cnt_q  <= rot_cnt_d;
      sel_q      <= sel_d;
      upd_q      <= upd_d;
      pos_q      <= pos_d;
      anode_q    <= anode_d;
      digit_q    <= digit_d;
      busy_q     <= busy_d;
      rot_tick_q <= rot_tick_d;
      for (int i = 0; i < 16; i++) msg_q[i] <= msg_d[i];
`ifdef SCAN_ROTATE_BOUNCE_EN
      dir_q      <= dir_d;
`endif
    end
  end

  assign anode     = anode_q;
  assign digit     = digit_q;
  assign pos       = pos_q;
  assign busy      = busy_q;
  assign rot_tick  = rot_tick_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_scan_rotate_ctrl.sv
// Bench for scan_rotate_ctrl: randomized and directed stimulus, cycle model of
// display/rotation behaviour, expected-output queue checked by a negedge monitor.
`timescale 1ns/1ps
module tb_scan_rotate_ctrl;
  localparam int SCAN_W  = 2;
  localparam int ROT_W   = 3;
  localparam int MSG_LEN = 8;
  localparam int SCAN_P  = 1 << SCAN_W;
  localparam int ROT_P   = 1 << ROT_W;
  localparam int W       = 14;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0, step = 1'b0, wr_en = 1'b0;
  logic [3:0] wr_addr = 4'h0, wr_data = 4'h0;
  logic [3:0] anode, digit, pos;
  logic       busy, rot_tick;
  logic [1:0] state_dbg;

  scan_rotate_ctrl #(.SCAN_W(SCAN_W), .ROT_W(ROT_W), .MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .step(step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .anode(anode), .digit(digit), .pos(pos), .busy(busy), .rot_tick(rot_tick),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: cycles since reset, mode, position, rotation phase, shown digit.
  int         m_cyc, m_mode, m_pos, m_rot, m_dir;
  logic       m_tick;
  logic [3:0] m_anode, m_digit;
  logic [3:0] m_buf [MSG_LEN];

  task automatic model_reset();
    m_cyc = 0; m_mode = M_IDLE; m_pos = 0; m_rot = 0; m_dir = 0;
    m_tick = 1'b0; m_anode = 4'b1111; m_digit = 4'h0;
    for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 4'h0;
  endtask

  task automatic model_advance();
`ifdef SCAN_ROTATE_BOUNCE_EN
    if (m_dir == 0) begin
      m_pos = (m_pos + 1) % MSG_LEN;
      if (m_pos == MSG_LEN - 4) m_dir = 1;
    end else begin
      m_pos = m_pos - 1;
      if (m_pos == 0) m_dir = 0;
    end
`else
    m_pos = (m_pos + 1) % MSG_LEN;
`endif
  endtask

  task automatic model_step();
    int sel;
    // A digit is refreshed one cycle after each completed scan period.
    if (m_cyc > 0 && m_cyc % SCAN_P == 0) begin
      sel     = (m_cyc / SCAN_P) % 4;
      m_anode = ~(4'b0001 << sel);
      m_digit = m_buf[(m_pos + 3 - sel) % MSG_LEN];
    end
    if (wr_en && int'(wr_addr) < MSG_LEN) m_buf[wr_addr] = wr_data;
    m_tick = 1'b0;
    if (stop) begin
      m_mode = M_IDLE; m_pos = 0; m_rot = 0; m_dir = 0;
    end else if (m_mode == M_RUN) begin
      if (pause) m_mode = M_PAUSE;
      else begin
        if (m_rot == ROT_P - 1) begin
          model_advance();
          m_tick = 1'b1;
        end
        m_rot = (m_rot + 1) % ROT_P;
      end
    end else begin
      if (step) model_advance();
      if (!pause && start) m_mode = M_RUN;
    end
    m_cyc++;
  endtask

  function automatic logic [W-1:0] exp_vec();
    return {m_anode, m_digit, 4'(m_pos), (m_mode == M_RUN), m_tick};
  endfunction

  // One clock of stimulus; entered and left at 1 ns after a rising edge.
  task automatic cycle(input logic st, input logic pa, input logic sp, input logic se,
                       input logic we, input logic [3:0] wa, input logic [3:0] wd);
    logic [W-1:0] e;
    start = st; pause = pa; stop = sp; step = se; wr_en = we; wr_addr = wa; wr_data = wd;
    model_step();
    e = exp_vec();
    @(posedge clk); #1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if ({anode, digit, pos, busy, rot_tick} !== {4'b1111, 4'h0, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s got anode=%b digit=%h pos=%0d busy=%b tick=%b exp anode=1111 digit=0 pos=0 busy=0 tick=0",
               tag, anode, digit, pos, busy, rot_tick);
    end
  endtask

  task automatic do_reset(input int n);
    start = 0; pause = 0; stop = 0; step = 0; wr_en = 0;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check_reset("rst_async");
    repeat (n) @(posedge clk);
    #1;
    check_reset("rst_hold");
    rst = 1'b1;
    model_reset();
  endtask

  task automatic wait_run_pos(input int target, input int limit);
    int n = 0;
    while (!(m_mode == M_RUN && m_pos == target) && n < limit) begin
      idle(1);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_pos got timeout after %0d cycles exp pos=%0d in RUN", n, target);
    end
  endtask

  task automatic wait_run_rot(input int target, input int limit);
    int n = 0;
    while (!(m_mode == M_RUN && m_rot == target) && n < limit) begin
      idle(1);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_rot got timeout after %0d cycles exp rot=%0d in RUN", n, target);
    end
  endtask

  always @(negedge clk) begin
    if (rst && exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {anode, digit, pos, busy, rot_tick};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL out_cmp t=%0t got anode=%b digit=%h pos=%0d busy=%b tick=%b st=%0d exp anode=%b digit=%h pos=%0d busy=%b tick=%b",
                 $time, anode, digit, pos, busy, rot_tick, state_dbg,
                 e[13:10], e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_por");
    rst = 1'b1;
    model_reset();

    // Load 0..7 and watch the idle scan.
    for (int i = 0; i < MSG_LEN; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 4'(i));
    idle(24);

    // Free run through a full wrap; a step while running must be ignored.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    idle(70);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    idle(3);

    // All three requests together at pos 5: stop wins.
    wait_run_pos(5, 100);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    idle(4);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    idle(2);

    // Pause at rotation phase 5, step while paused, resume.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    wait_run_rot(5, 100);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    idle(8);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    idle(10);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    idle(12);

    // Out-of-range writes are dropped; an in-range write shows on the next matching scan.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 4'hF);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 4'hE);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'hA);
    idle(20);

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Reset in the middle of a run.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    idle(13);
    do_reset(2);
    idle(20);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    idle(20);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_rotate_ctrl.md
SCAN_ROTATE_CTRL -- requirements
Module: scan_rotate_ctrl

Interface
REQ-001 Parameter SCAN_W, default 16, SHALL set the scan prescaler width; one digit-scan tick every 2^SCAN_W clk cycles.
REQ-002 Parameter ROT_W, default 22, SHALL set the rotation prescaler width; one rotation tick every 2^ROT_W clk cycles while running.
REQ-003 Parameter MSG_LEN, default 16, range 4..16, SHALL set the message buffer depth in nibbles.
REQ-004 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be a level request to enter or resume RUN.
REQ-007 pause  input  1  SHALL be a level request to freeze rotation.
REQ-008 stop  input  1  SHALL be a level request to return to IDLE with position 0.
REQ-009 step  input  1  SHALL be a single-cycle pulse advancing the position by one when not in RUN.
REQ-010 wr_en  input  1  SHALL be the message-buffer write strobe.
REQ-011 wr_addr  input  4  SHALL be the message-buffer write address.
REQ-012 wr_data  input  4  SHALL be the nibble written.
REQ-013 anode  output  4  SHALL be the registered, active-low digit enables; anode[3] is the leftmost digit.
REQ-014 digit  output  4  SHALL be the registered nibble for the enabled digit, for an external 7-segment decoder.
REQ-015 pos  output  4  SHALL be the current rotation position (buffer index shown on the leftmost digit).
REQ-016 busy  output  1  SHALL be high exactly while the FSM is in RUN.
REQ-017 rot_tick  output  1  SHALL pulse high for one cycle on each position advance caused by the rotation prescaler.

Function
REQ-018 Scan counter SHALL increment every cycle, wrapping; scan tick when it equals all ones.
REQ-019 On scan tick, select sel[1:0] SHALL increment, wrapping 3 to 0; anode and digit SHALL update in the following cycle.
REQ-020 anode SHALL have exactly one bit low (bit sel) after the first scan tick; digit SHALL equal buf[(pos + 3 - sel) mod MSG_LEN].
REQ-021 FSM states: IDLE, RUN, PAUSE; priority stop > pause > start when asserted in the same cycle.
REQ-022 IDLE: start -> RUN; rotation counter held at 0.
REQ-023 RUN: pause -> PAUSE (counter held); stop -> IDLE (pos and counter cleared next cycle).
REQ-024 PAUSE: start -> RUN (counter resumes from held value); stop -> IDLE.
REQ-025 In RUN the rotation counter SHALL increment every cycle; at all ones pos SHALL advance one step next cycle and rot_tick SHALL pulse in that same cycle.
REQ-026 step in IDLE or PAUSE SHALL advance pos by one next cycle; step in RUN SHALL be ignored.
REQ-027 Forward advance SHALL wrap pos from MSG_LEN-1 to 0.
REQ-028 wr_en SHALL write buf[wr_addr] in any state; writes with wr_addr >= MSG_LEN SHALL be ignored; a written nibble SHALL appear on digit at the next scan update that selects it.

Reset
REQ-029 While rst low: state IDLE, scan counter, rotation counter, sel, pos 0, buffer all 4'h0, anode 4'b1111, digit 4'h0, busy 0, rot_tick 0.
REQ-030 Reset asserted mid-RUN SHALL abort immediately; operation resumes only via start after rst deasserts.

Configuration
REQ-031 Macro SCAN_ROTATE_BOUNCE_EN defined: a direction flag (reset forward) SHALL make pos ping-pong, reversing after reaching MSG_LEN-4 going forward and after reaching 0 going backward; step follows the current direction; stop clears the flag to forward.
REQ-032 Macro SCAN_ROTATE_BOUNCE_EN undefined: pos SHALL only move forward with wrap per REQ-027; no direction state exists.

Verification (SCAN_W=2, ROT_W=3, MSG_LEN=8)
REQ-033 Reset, write buf 0..7 = 0..7, no start -> anode cycles 1110,1101,1011,0111 every 4 cycles; digit 3,2,1,0 respectively; pos 0.
REQ-034 start held 1 cycle -> busy 1; rot_tick every 8 cycles; pos 0,1,..,7,0 (wrap verified).
REQ-035 start, pause and stop asserted together in RUN with pos=5 -> next cycle IDLE, pos 0, busy 0.
REQ-036 pause in RUN with rotation counter at 5, hold 20 cycles, start -> first rot_tick 3 cycles after resume; step during RUN ignored, step during PAUSE advances pos.
REQ-037 wr_addr 9 with wr_en -> buffer unchanged; rst low mid-RUN -> all outputs at REQ-029 values within same cycle.
REQ-038 With SCAN_ROTATE_BOUNCE_EN: start -> pos 0,1,2,3,4,3,2,1,0,1.
